pwm_gen: RTL and testbench

- Downstream consumer of the triangle-wave compare generator. Turns its WIDTH-bit compare value into a PWM output, e.g. for a fading LED.
- Runs a prescaled, free-running sawtooth period counter. Latches the compare value only at period boundaries, so the output never glitches mid-period.
- Emits a one-cycle period_end strobe. The strobe can drive the compare generator's update input, which steps the fade once per PWM period.

---
 rtl/pwm_gen_if.sv | 28 ++
 rtl/pwm_gen.sv | 71 +++++++
 tb/tb_pwm_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gen_if.sv
// Bus bundle between the PWM generator and whoever drives its controls.
// The master drives enable, prescale and compare; the slave returns the PWM output and period strobe.
interface pwm_gen_if #(
  parameter int WIDTH      = 12,
  parameter int PRESCALE_W = 8
);
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cmp;
  logic                  pwm_out;
  logic                  period_end;

  modport master (
    output en,
    output prescale,
    output cmp,
    input  pwm_out,
    input  period_end
  );

  modport slave (
    input  en,
    input  prescale,
    input  cmp,
    output pwm_out,
    output period_end
  );
endinterface

// File: rtl/pwm_gen.sv
// Prescaled sawtooth PWM generator with period-boundary compare shadowing and a period_end strobe.
// Optional macro PWM_FULL_ON_EN: an all-ones compare value gives 100% duty instead of 2^WIDTH-1 ticks.
module pwm_gen #(
  parameter int WIDTH      = 12,
  parameter int PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_gen_if.slave   bus
);

  localparam logic [WIDTH-1:0]      L_CTR_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      L_CTR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] L_PSC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] r_psc;
  logic [WIDTH-1:0]      r_ctr;
  logic [WIDTH-1:0]      r_cmp_sh;
  logic                  r_pwm_out;
  logic                  r_period_end;

  logic                  w_tick;
  logic                  w_ctr_max;
  logic                  w_pwm_next;

  // >= rather than == so a prescale lowered below psc ticks on the next clock instead of wrapping
  assign w_tick    = (r_psc >= bus.prescale);
  assign w_ctr_max = (r_ctr == L_CTR_MAX);

`ifdef PWM_FULL_ON_EN
  assign w_pwm_next = (r_cmp_sh == L_CTR_MAX) || (r_ctr < r_cmp_sh);
`else
  assign w_pwm_next = (r_ctr < r_cmp_sh);
`endif

  // Prescaler, period counter, compare shadow and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc        <= {PRESCALE_W{1'b0}};
      r_ctr        <= {WIDTH{1'b0}};
      r_cmp_sh     <= {WIDTH{1'b0}};
      r_pwm_out    <= 1'b0;
      r_period_end <= 1'b0;
    end else if (!bus.en) begin
      r_psc        <= {PRESCALE_W{1'b0}};
      r_ctr        <= {WIDTH{1'b0}};
      r_cmp_sh     <= bus.cmp;
      r_pwm_out    <= 1'b0;
      r_period_end <= 1'b0;
    end else begin
      r_pwm_out <= w_pwm_next;
      if (w_tick) begin
        r_psc <= {PRESCALE_W{1'b0}};
        r_ctr <= r_ctr + L_CTR_ONE;
        if (w_ctr_max) begin
          r_cmp_sh     <= bus.cmp;
          r_period_end <= 1'b1;
        end else begin
          r_period_end <= 1'b0;
        end
      end else begin
        r_psc        <= r_psc + L_PSC_ONE;
        r_period_end <= 1'b0;
      end
    end
  end

  assign bus.pwm_out    = r_pwm_out;
  assign bus.period_end = r_period_end;

endmodule

// File: tb/tb_pwm_gen.sv
// Randomised and directed bench for pwm_gen, checked against a tick/period arithmetic model.
module tb_pwm_gen;

  localparam int W    = 4;
  localparam int PW   = 4;
  localparam int NPER = 16;

  logic clk = 1'b0;
  logic rst_n;

  pwm_gen_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  pwm_gen #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: total ticks since enable, clocks since last tick, latched duty
  int m_ticks;
  int m_sub;
  int m_duty;
  int m_pwm;
  int m_pe;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ticks = 0;
    m_sub   = 0;
    m_duty  = 0;
    m_pwm   = 0;
    m_pe    = 0;
  endtask

  task automatic model_clock();
    int nxt_pwm;
    if (!rst_n) begin
      model_reset();
    end else if (!bus.en) begin
      m_ticks = 0;
      m_sub   = 0;
      m_duty  = int'(bus.cmp);
      m_pwm   = 0;
      m_pe    = 0;
    end else begin
      nxt_pwm = ((m_ticks % NPER) < m_duty) ? 1 : 0;
`ifdef PWM_FULL_ON_EN
      if (m_duty == NPER - 1) nxt_pwm = 1;
`endif
      if (m_sub >= int'(bus.prescale)) begin
        m_sub   = 0;
        m_ticks = m_ticks + 1;
        m_pe    = ((m_ticks % NPER) == 0) ? 1 : 0;
        if (m_pe == 1) m_duty = int'(bus.cmp);
      end else begin
        m_sub = m_sub + 1;
        m_pe  = 0;
      end
      m_pwm = nxt_pwm;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_eq("pwm_out", int'(bus.pwm_out), m_pwm);
    check_eq("period_end", int'(bus.period_end), m_pe);
    check_eq("ctr", int'(dut.r_ctr), m_ticks % NPER);
    check_eq("psc", int'(dut.r_psc), m_sub);
  endtask

  // Window from one period_end to the next; optionally change cmp partway through
  task automatic measure(input int chg_at, input int chg_val, output int hi, output int len);
    int guard;
    guard = 0;
    hi    = 0;
    len   = 0;
    while (m_pe == 0 && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) check_eq("pe_wait_timeout", 0, 1);
    do begin
      step();
      len++;
      if (bus.pwm_out === 1'b1) hi++;
      if (len == chg_at) bus.cmp = W'(chg_val);
    end while (m_pe == 0 && len < 2000);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_pwm"}, int'(bus.pwm_out), 0);
    check_eq({tag, "_pe"}, int'(bus.period_end), 0);
    check_eq({tag, "_ctr"}, int'(dut.r_ctr), 0);
    check_eq({tag, "_psc"}, int'(dut.r_psc), 0);
    check_eq({tag, "_cmp_sh"}, int'(dut.r_cmp_sh), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    int len;
    int prev;
    int guard;
    int cnt_hi;
    int cnt_pe;

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.prescale = 4'd0;
    bus.cmp      = 4'd4;
    model_reset();
    #12;
    check_eq("rst_pwm", int'(bus.pwm_out), 0);
    check_eq("rst_pe", int'(bus.period_end), 0);
    check_eq("rst_ctr", int'(dut.r_ctr), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // basic duty and period
    measure(-1, 0, hi, len);
    check_eq("basic_hi", hi, 4);
    check_eq("basic_len", len, 16);
    measure(-1, 0, hi, len);
    check_eq("basic_hi2", hi, 4);

    // shadow update at ctr=2
    measure(2, 10, hi, len);
    check_eq("shadow_cur_hi", hi, 4);
    measure(-1, 0, hi, len);
    check_eq("shadow_next_hi", hi, 10);
    check_eq("shadow_next_len", len, 16);

    // prescaler
    bus.prescale = 4'd2;
    bus.cmp      = 4'd4;
    measure(-1, 0, hi, len);
    measure(-1, 0, hi, len);
    check_eq("psc_hi", hi, 12);
    check_eq("psc_len", len, 48);

    // prescale lowered below current psc
    bus.prescale = 4'd9;
    guard = 0;
    while (m_sub != 7 && guard < 100) begin
      step();
      guard++;
    end
    check_eq("dyn_reach_psc7", int'(dut.r_psc), 7);
    bus.prescale = 4'd2;
    prev = m_ticks;
    step();
    check_eq("dyn_ctr_next", int'(dut.r_ctr), (prev + 1) % NPER);
    bus.prescale = 4'd0;

    // duty extremes
    bus.cmp = 4'd0;
    measure(-1, 0, hi, len);
    measure(-1, 0, hi, len);
    check_eq("cmp0_hi", hi, 0);
    check_eq("cmp0_len", len, 16);
    bus.cmp = 4'd15;
    measure(-1, 0, hi, len);
    measure(-1, 0, hi, len);
`ifdef PWM_FULL_ON_EN
    check_eq("cmp15_hi", hi, 16);
`else
    check_eq("cmp15_hi", hi, 15);
`endif

    // enable dropped at ctr=7
    bus.cmp = 4'd5;
    measure(-1, 0, hi, len);
    for (int i = 0; i < 7; i++) step();
    check_eq("en_at_ctr7", int'(dut.r_ctr), 7);
    bus.en  = 1'b0;
    bus.cmp = 4'd9;
    step();
    check_eq("en_drop_pwm", int'(bus.pwm_out), 0);
    cnt_pe = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.period_end === 1'b1) cnt_pe++;
    end
    check_eq("en_drop_no_pe", cnt_pe, 0);
    bus.en = 1'b1;
    cnt_hi = 0;
    cnt_pe = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.pwm_out === 1'b1) cnt_hi++;
      if (bus.period_end === 1'b1) cnt_pe++;
    end
    check_eq("reen_hi", cnt_hi, 9);
    check_eq("reen_pe", cnt_pe, 1);

    // async reset while period_end is high, then while pwm_out is high
    check_eq("pre_rst_pe", int'(bus.period_end), 1);
    reset_pulse("rst_pe");
    measure(-1, 0, hi, len);
    for (int i = 0; i < 3; i++) step();
    check_eq("pre_rst_pwm", int'(bus.pwm_out), 1);
    reset_pulse("rst_pwm");

    // randomised run
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) bus.prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  bus.cmp      = W'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) bus.en       = ~bus.en;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
